// File: rtl/pwm_duty_decoder_if.sv
// PWM pair in, recovered duty/speed/status out, seen from the decoder (slave)
// and from whoever drives the pair and consumes the reports (master).
interface pwm_duty_decoder_if;
  localparam int unsigned DW = 12;

  logic          PWM1;
  logic          PWM2;
  logic [DW-1:0] duty;
  logic [DW-1:0] spd;
  logic          vld;
  logic          ovlp;

  modport master (output PWM1, PWM2, input duty, spd, vld, ovlp);
  modport slave  (input PWM1, PWM2, output duty, spd, vld, ovlp);
endinterface

// File: rtl/pwm_duty_decoder.sv
// Recovers the 12-bit duty and signed speed command from one complementary PWM
// pair once per period; flags shoot-through and static (edge-less) outputs.
module pwm_duty_decoder #(
  parameter int unsigned NONOVERLAP = 32,
  parameter int unsigned PERIOD_MAX = 4352,
  parameter bit          INVERT     = 1'b0
) (
  input logic               clk,
  input logic               rst_n,
  pwm_duty_decoder_if.slave pwm
);
  localparam int unsigned DW  = 12;
  localparam int unsigned CW  = 13;
  localparam int unsigned SW  = CW + 1;
  localparam int unsigned LW  = $clog2(PERIOD_MAX + 1);

  localparam logic [CW-1:0] HI_SAT   = '1;
  localparam logic [DW-1:0] DUTY_MAX = '1;
  localparam logic [DW-1:0] DUTY_MID = 12'h800;
  localparam logic [LW-1:0] LVL_TO   = LW'(PERIOD_MAX - 1);
  localparam logic [SW-1:0] NOV      = SW'(NONOVERLAP);

  typedef enum logic [1:0] {IDLE, MEAS_HI, MEAS_LO} state_e;

  state_e        state_q,   state_d;
  logic [CW-1:0] hi_cnt_q,  hi_cnt_d;
  logic [LW-1:0] lvl_cnt_q, lvl_cnt_d;
  logic [DW-1:0] duty_q,    duty_d;
  logic [DW-1:0] spd_q,     spd_d;
  logic          vld_q,     vld_d;
  logic          ovlp_q,    ovlp_d;
  logic          p1_q, p1_qq, p2_q;
  logic [1:0]    pv_q;

  logic          rise, fall, tmo, rpt;
  logic [SW-1:0] meas_sum;
  logic [DW-1:0] meas_duty, rpt_duty;
  logic [CW-1:0] duty_ext, mid_ext, spd_diff;
  logic [DW-1:0] spd_sat;

  // p1_qq only holds a real sample two cycles after reset; until then the
  // reset value would fake an edge if PWM1 is already high.
  assign rise = pv_q[1] &  p1_q & ~p1_qq;
  assign fall = pv_q[1] & ~p1_q &  p1_qq;
  assign tmo  = (lvl_cnt_q == LVL_TO) & ~rise & ~fall;

  // Report value: measured high time plus dead time, or the static level.
  always_comb begin
    meas_sum  = {1'b0, hi_cnt_q} + NOV;
    meas_duty = (meas_sum > {2'b00, DUTY_MAX}) ? DUTY_MAX : meas_sum[DW-1:0];
    if (tmo) rpt_duty = p1_q ? DUTY_MAX : '0;
    else     rpt_duty = meas_duty;
    duty_ext = {1'b0, rpt_duty};
    mid_ext  = {1'b0, DUTY_MID};
    spd_diff = INVERT ? (mid_ext - duty_ext) : (duty_ext - mid_ext);
    if (spd_diff[CW-1] == spd_diff[CW-2]) spd_sat = spd_diff[DW-1:0];
    else if (!spd_diff[CW-1])             spd_sat = 12'h7FF;
    else                                  spd_sat = 12'h800;
  end

  // Next state, counters and report outputs.
  always_comb begin
    state_d   = state_q;
    hi_cnt_d  = hi_cnt_q;
    rpt       = 1'b0;
    lvl_cnt_d = (rise | fall | tmo) ? '0 : lvl_cnt_q + LW'(1);
    duty_d    = duty_q;
    spd_d     = spd_q;
    vld_d     = 1'b0;
    ovlp_d    = ovlp_q | (p1_q & p2_q);

    // The rise cycle is itself the first high cycle, so the count starts at 1.
    unique case (state_q)
      IDLE: begin
        if (rise) begin
          hi_cnt_d = CW'(1);
          state_d  = MEAS_HI;
        end
      end
      MEAS_HI: begin
        if (fall)                           state_d  = MEAS_LO;
        else if (p1_q && hi_cnt_q != HI_SAT) hi_cnt_d = hi_cnt_q + CW'(1);
      end
      MEAS_LO: begin
        if (rise) begin
          rpt      = 1'b1;
          hi_cnt_d = CW'(1);
          state_d  = MEAS_HI;
        end
      end
      default: state_d = IDLE;
    endcase

    if (tmo) begin
      rpt      = 1'b1;
      hi_cnt_d = '0;
      state_d  = IDLE;
    end

    if (rpt) begin
      duty_d = rpt_duty;
      spd_d  = spd_sat;
      vld_d  = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      hi_cnt_q  <= '0;
      lvl_cnt_q <= '0;
      p1_q      <= 1'b0;
      p1_qq     <= 1'b0;
      p2_q      <= 1'b0;
      pv_q      <= '0;
      duty_q    <= DUTY_MID;
      spd_q     <= '0;
      vld_q     <= 1'b0;
      ovlp_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      hi_cnt_q  <= hi_cnt_d;
      lvl_cnt_q <= lvl_cnt_d;
      p1_q      <= pwm.PWM1;
      p1_qq     <= p1_q;
      p2_q      <= pwm.PWM2;
      pv_q      <= {pv_q[0], 1'b1};
      duty_q    <= duty_d;
      spd_q     <= spd_d;
      vld_q     <= vld_d;
      ovlp_q    <= ovlp_d;
    end
  end

  assign pwm.duty = duty_q;
  assign pwm.spd  = spd_q;
  assign pwm.vld  = vld_q;
  assign pwm.ovlp = ovlp_q;
endmodule

// File: doc/pwm_duty_decoder.md
# pwm_duty_decoder

Receive-side counterpart of the motor drive PWM path: watches one complementary PWM pair (PWM1/PWM2 as produced by the 12-bit, 4096-cycle-period PWM generator with non-overlap) and recovers the 12-bit duty and the equivalent signed speed command once per period. Used in the motor/plant model and in self-check logic, so commanded wheel speed can be closed against what actually reaches the bridge. It also flags shoot-through (PWM1 and PWM2 high together) and dead outputs (no edges for longer than a period).

## Interface
- NONOVERLAP, 32: dead-time cycles of the generator; added back to the measured PWM1 high time.
- PERIOD_MAX, 4352: cycles without any PWM1 edge before a static-level report.
- INVERT, 0: 0 → spd = duty − 0x800 (left side); 1 → spd = 0x800 − duty (right side).
- clk  input  1  system clock; all logic on rising edge.
- rst_n  input  1  synchronous, active-low reset.
- PWM1  input  1  high-side PWM from the generator (same clock domain).
- PWM2  input  1  complementary PWM from the generator.
- duty  output  12  recovered duty, unsigned.
- spd  output  12  recovered speed, signed two's complement, saturated.
- vld  output  1  one-cycle pulse; duty/spd updated in the same cycle.
- ovlp  output  1  sticky shoot-through flag.

## Operation
- Inputs registered once (p1_q, p2_q); a second register of p1_q (p1_qq) gives edges: rise = p1_q & ~p1_qq, fall = ~p1_q & p1_qq.
- States:
  - IDLE: wait for rise → MEAS_HI; clear hi_cnt.
  - MEAS_HI: hi_cnt += 1 per cycle with p1_q high; fall → MEAS_LO.
  - MEAS_LO: rise → report, clear hi_cnt, → MEAS_HI.
- hi_cnt is 13 bits and saturates at 0x1FFF.
- Report on a rise in MEAS_LO:
  - duty = min(hi_cnt + NONOVERLAP, 0xFFF).
  - spd is computed per INVERT in 13-bit signed arithmetic, then saturated to [−2048, +2047].
  - vld = 1 for exactly one cycle.
- Timeout:
  - lvl_cnt counts cycles since the last PWM1 edge of either polarity, and clears on any edge.
  - If lvl_cnt reaches PERIOD_MAX−1 in any state: report duty = 0x000 if p1_q is low, 0xFFF if high; spd per the same rule; vld pulse; lvl_cnt clears; state → IDLE.
  - The report repeats every PERIOD_MAX cycles while the level stays static.
- ovlp: set on any cycle with p1_q & p2_q; cleared only by reset.
- The first rise after reset or timeout arms the measurement only and produces no vld. The first valid report is on the second rise.
- A rise and a timeout in the same cycle: the rise wins; report the measured duty and clear lvl_cnt.

## Timing
- Reset (rst_n low at a clk edge):
  - duty = 0x800, spd = 0x000, vld = 0, ovlp = 0.
  - State = IDLE; hi_cnt, lvl_cnt, p1_q, p1_qq, p2_q = 0.
- Latency: vld, duty and spd update at the second rising clk edge after the PWM1 rise is presented at the input.
- duty/spd hold between reports; vld is never high two cycles in a row.
- Measurement resolution: 1 clk; duties ≤ NONOVERLAP produce no PWM1 pulse and are reported as 0x000 via timeout.
- Reset mid-period discards the partial measurement; the next report follows two rises.

## Test plan
- Reset: hold rst_n low 3 cycles with PWM toggling → duty = 0x800, spd = 0, vld = 0, ovlp = 0; no vld during reset.
- Generator, duty 0xC00, NONOVERLAP 32, INVERT = 0 (PWM1 high 3040 cycles per 4096):
  - No vld at the first rise.
  - From the second rise, vld every 4096 cycles with duty = 0xC00, spd = 0x400.
- INVERT = 1, duty 0x400 → duty = 0x400, spd = 0x400; duty 0xA00 → spd = 0xE00 (−512).
- PWM1 held low 10000 cycles (INVERT = 1):
  - vld at cycles PERIOD_MAX and 2·PERIOD_MAX, duty = 0x000, spd = 0x7FF (saturated).
  - Same test with PWM1 held high, INVERT = 0 → duty = 0xFFF, spd = 0x7FF.
- PWM1 and PWM2 both high for 1 cycle mid-stream → ovlp = 1 two edges later and stays 1; duty reports are unaffected.
- rst_n low for 1 cycle halfway through a PWM1 high phase:
  - No vld at the next rise; the next vld comes at the rise after that.
  - The reported duty is correct, with no partial-period value.
